// File: rtl/fpu_wb_bridge.sv
// Wishbone slave to FPU register-file bridge with byte-lane read-modify-write,
// bounded wait for the register file's acknowledge, and cycle abort.
//
// state  | meaning
// IDLE   | no transfer; reg-file interface parked at address 0
// RMW_RD | read current word so a partial write can merge byte lanes
// ACCESS | single-cycle reg-file access; write strobe pulses here
// WAIT   | holding address until reg_ack or timeout
// RESP   | one-cycle Wishbone acknowledge with captured data
module fpu_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h30,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] reg_addr,
  output logic        reg_wren,
  output logic [31:0] reg_wrdata,
  input  logic        reg_ack,
  input  logic [31:0] reg_rddata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RMW_RD = 3'd1,
    ACCESS = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [7:0]  wait_cnt;

  logic        req;
  logic        in_window;
  logic        aligned;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] ack_data;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign in_window = (wbs_adr_i >= BASE_ADDR) && ((wbs_adr_i - BASE_ADDR) < ADDR_SPAN);
  assign aligned   = (wbs_adr_i[1:0] == 2'b00);
  assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
  assign merged    = (wdat_q & lane_mask) | (reg_rddata & ~lane_mask);
  // Writes acknowledge with zero data; reads return the register contents.
  assign ack_data  = we_q ? 32'h0 : reg_rddata;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      wdat_q     <= 32'h0;
      sel_q      <= 4'h0;
      we_q       <= 1'b0;
      wait_cnt   <= 8'h0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      reg_addr   <= 32'h0;
      reg_wren   <= 1'b0;
      reg_wrdata <= 32'h0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      reg_wren  <= 1'b0;
      if (state != IDLE && !wbs_cyc_i) begin
        state      <= IDLE;
        reg_addr   <= 32'h0;
        reg_wrdata <= 32'h0;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              if (!in_window || !aligned) begin
                state     <= RESP;
                wbs_ack_o <= 1'b1;
              end else begin
                addr_q <= wbs_adr_i;
                wdat_q <= wbs_dat_i;
                sel_q  <= wbs_sel_i;
                we_q   <= wbs_we_i;
                if (wbs_we_i && wbs_sel_i == 4'h0) begin
                  state     <= RESP;
                  wbs_ack_o <= 1'b1;
                end else if (wbs_we_i && wbs_sel_i != 4'hF) begin
                  state    <= RMW_RD;
                  reg_addr <= wbs_adr_i;
                end else begin
                  state      <= ACCESS;
                  reg_addr   <= wbs_adr_i;
                  reg_wren   <= wbs_we_i;
                  reg_wrdata <= wbs_dat_i;
                end
              end
            end
          end
          RMW_RD: begin
            state      <= ACCESS;
            reg_addr   <= addr_q;
            reg_wren   <= 1'b1;
            reg_wrdata <= merged;
            wdat_q     <= merged;
          end
          ACCESS: begin
            wait_cnt <= 8'h0;
            if (reg_ack) begin
              state      <= RESP;
              wbs_ack_o  <= 1'b1;
              wbs_dat_o  <= ack_data;
              reg_addr   <= 32'h0;
              reg_wrdata <= 32'h0;
            end else begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (reg_ack || wait_cnt == CNT_LAST) begin
              state      <= RESP;
              wbs_ack_o  <= 1'b1;
              wbs_dat_o  <= reg_ack ? ack_data : 32'h0;
              reg_addr   <= 32'h0;
              reg_wrdata <= 32'h0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          RESP: begin
            state <= IDLE;
          end
          default: begin
            state      <= IDLE;
            reg_addr   <= 32'h0;
            reg_wrdata <= 32'h0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_wb_bridge.sv
// Scoreboard bench for fpu_wb_bridge: a register-file model answers the bridge,
// a reference memory predicts ack data, latency and every write strobe.
module tb_fpu_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] SPAN = 32'h30;
  localparam int          T    = 16;
  localparam int          NW   = 12;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] reg_addr;
  logic        reg_wren;
  logic [31:0] reg_wrdata;
  logic        reg_ack;
  logic [31:0] reg_rddata;

  fpu_wb_bridge #(.BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .TIMEOUT(T)) dut (
    .clk(clk), .rst_l(rst_l),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .reg_addr(reg_addr), .reg_wren(reg_wren), .reg_wrdata(reg_wrdata),
    .reg_ack(reg_ack), .reg_rddata(reg_rddata)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Register-file device: acks once the address has been held ack_delay cycles.
  logic [31:0] dev_mem [0:15];
  int          dly_cnt = 0;
  int          ack_delay = 0;
  logic        dev_hit;
  logic [31:0] dev_off;
  logic [3:0]  dev_idx;

  always_comb begin
    dev_off    = reg_addr - BASE;
    dev_idx    = dev_off[5:2];
    dev_hit    = (reg_addr >= BASE) && (reg_addr < BASE + SPAN) && (reg_addr[1:0] == 2'b00);
    reg_rddata = 32'hDEAD_BEEF;
    reg_ack    = 1'b0;
    if (dev_hit) begin
      reg_rddata = dev_mem[dev_idx];
      reg_ack    = (dly_cnt >= ack_delay);
    end
  end

  always @(posedge clk) begin
    if (reg_addr == 32'h0) dly_cnt <= 0;
    else dly_cnt <= dly_cnt + 1;
    if (reg_wren && dev_hit) dev_mem[dev_idx] <= reg_wrdata;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  typedef struct { logic [31:0] data; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [31:0] ref_mem [0:15];

  // Monitor: compares every ack and every write strobe against the queues.
  always @(negedge clk) begin : monitor
    rsp_t r;
    wr_t  w;
    if (rst_l) begin
      if (wbs_ack_o) begin
        if (rsp_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else begin
          r = rsp_q.pop_front();
          check("ack_data", wbs_dat_o, r.data);
          check("ack_cycle", cyc_n, r.cyc);
          check("resp_reg_addr", reg_addr, 32'h0);
        end
      end else begin
        check("idle_dat_o", wbs_dat_o, 32'h0);
      end
      if (reg_wren) begin
        if (wr_q.size() == 0) check("unexpected_wren", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", reg_addr, w.addr);
          check("wr_data", reg_wrdata, w.data);
        end
      end
    end
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
    wbs_adr_i = a; wbs_we_i = we; wbs_sel_i = s; wbs_dat_i = d;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
  endtask

  // Called just after a rising edge with the bridge idle.
  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] s,
                       input logic [31:0] d, input int dly);
    logic        ok;
    int          idx;
    int          lat;
    int          eff;
    logic [31:0] off;
    logic [31:0] m;
    logic        got;
    rsp_t        r;
    wr_t         w;
    ok  = (a >= BASE) && (a < BASE + SPAN) && (a[1:0] == 2'b00);
    off = a - BASE;
    idx = ok ? int'(off[5:2]) : 0;
    r.data = 32'h0;
    if (!ok || (we && s == 4'h0)) lat = 1;
    else if (we && s != 4'hF) begin
      eff = (dly > 0) ? dly - 1 : 0;
      lat = 3 + imin(eff, T);
    end else begin
      lat = 2 + imin(dly, T);
      if (!we && dly <= T) r.data = ref_mem[idx];
    end
    if (ok && we && s != 4'h0) begin
      m = lane_mask(s);
      w.addr = a;
      w.data = (d & m) | (ref_mem[idx] & ~m);
      wr_q.push_back(w);
      ref_mem[idx] = w.data;
    end
    r.cyc = cyc_n + lat;
    rsp_q.push_back(r);
    ack_delay = dly;
    drive(a, we, s, d);
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = wbs_ack_o;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL txn_timeout: no ack for addr %h within 64 cycles", a);
    end
    @(posedge clk); #1;
    release_bus();
  endtask

  int dly_tab [10] = '{0, 0, 0, 1, 2, 5, T-1, T, T+1, 255};

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [3:0]  s;
    int          r;
    int          acks;
    rsp_t        e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_addr", reg_addr, 32'h0);
    check("rst_wren", {31'h0, reg_wren}, 32'h0);
    check("rst_wrdata", reg_wrdata, 32'h0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NW; i++) issue(BASE + 32'(4*i), 1'b1, 4'hF, $urandom, 0);

    issue(BASE + 32'h4, 1'b1, 4'hF, 32'h3F80_0000, 0);
    issue(BASE + 32'hC, 1'b1, 4'hF, 32'h4040_0000, 0);
    issue(BASE + 32'hC, 1'b0, 4'hF, 32'h0, 0);
    issue(BASE + 32'h0, 1'b1, 4'hF, 32'h5555_6789, 0);
    issue(BASE + 32'h0, 1'b1, 4'b0011, 32'hAAAA_1234, 0);
    issue(BASE + 32'h0, 1'b0, 4'hF, 32'h0, 0);
    issue(BASE + 32'h18, 1'b0, 4'hF, 32'h0, 255);
    issue(BASE + 32'h2, 1'b0, 4'hF, 32'h0, 0);
    issue(BASE + 32'h8, 1'b1, 4'h0, 32'h1234_5678, 0);
    issue(BASE + 32'h8, 1'b0, 4'hF, 32'h0, 3);
    issue(BASE + 32'h10, 1'b1, 4'b0110, 32'h1357_9BDF, 4);
    issue(BASE + SPAN, 1'b1, 4'hF, 32'hFFFF_FFFF, 0);

    // Request held across the ack starts a second transaction.
    ack_delay = 0;
    e.data = ref_mem[4];
    e.cyc  = cyc_n + 2;
    rsp_q.push_back(e);
    e.cyc  = cyc_n + 5;
    rsp_q.push_back(e);
    drive(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
    acks = 0;
    for (int k = 0; k < 40 && acks < 2; k++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    check("b2b_ack_count", acks, 2);
    @(posedge clk); #1;
    release_bus();

    // Abort during the read half of a partial write.
    ack_delay = 0;
    drive(BASE + 32'h14, 1'b1, 4'b1100, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check("rmw_addr", reg_addr, BASE + 32'h14);
    check("rmw_wren", {31'h0, reg_wren}, 32'h0);
    release_bus();
    @(posedge clk); #1;
    check("abort_addr", reg_addr, 32'h0);
    check("abort_ack", {31'h0, wbs_ack_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Reset while waiting on an unresponsive register.
    ack_delay = 255;
    drive(BASE + 32'h8, 1'b0, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("wait_addr", reg_addr, BASE + 32'h8);
    rst_l = 1'b0;
    release_bus();
    @(posedge clk); #1;
    check("mid_rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("mid_rst_dat", wbs_dat_o, 32'h0);
    check("mid_rst_addr", reg_addr, 32'h0);
    check("mid_rst_wren", {31'h0, reg_wren}, 32'h0);
    check("mid_rst_wrdata", reg_wrdata, 32'h0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) a = BASE + 32'(4 * $urandom_range(0, NW-1));
      else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, NW-1)) + 32'($urandom_range(1, 3));
      else if (r == 8) a = BASE + SPAN + 32'(4 * $urandom_range(0, 3));
      else a = BASE - 32'(4 * $urandom_range(1, 4));
      r = $urandom_range(0, 3);
      if (r == 0) s = 4'hF;
      else if (r == 1) s = 4'h0;
      else s = 4'($urandom_range(1, 14));
      issue(a, 1'($urandom_range(0, 1)), s, $urandom, dly_tab[$urandom_range(0, 9)]);
    end

    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) check("mem_final", dev_mem[i], ref_mem[i]);
    check("rsp_q_empty", rsp_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
